// File: rtl/subframe_decoder_if.sv
// ---------------------------------------------------------------------------
// subframe_decoder_if
//   Bundles the serial biphase-mark input and the decoded-sample outputs of
//   subframe_decoder.
//
//   din          serial biphase cell stream, one cell per clk
//   dout[19:0]   decoded audio sample
//   vout         one-cycle strobe, sample and flags valid
//   channel_b    sample came from a W (right) subframe
//   block_start  sample came from a B subframe
//   cbit         channel-status bit of the sample
//   parity_err   even-parity failure on the sample
//   frame_idx    frame number within the 192-frame block
//   locked       decoder synchronised to the stream
//   sync_err     one-cycle strobe on loss of lock
//
//   master : decoder side (consumes din, drives the sample outputs)
//   slave  : stream source / sample consumer side
// ---------------------------------------------------------------------------
interface subframe_decoder_if;
  logic        din;
  logic [19:0] dout;
  logic        vout;
  logic        channel_b;
  logic        block_start;
  logic        cbit;
  logic        parity_err;
  logic [7:0]  frame_idx;
  logic        locked;
  logic        sync_err;

  modport master (
    input  din,
    output dout, vout, channel_b, block_start, cbit, parity_err,
           frame_idx, locked, sync_err
  );

  modport slave (
    output din,
    input  dout, vout, channel_b, block_start, cbit, parity_err,
           frame_idx, locked, sync_err
  );
endinterface

// File: rtl/subframe_decoder.sv
// ---------------------------------------------------------------------------
// subframe_decoder
//   Decodes a biphase-mark subframe stream (64 cells per subframe: 8-cell
//   preamble followed by 28 two-cell bits: 4 aux, 20 data MSB first, V, U,
//   C, P). Hunts for any preamble, then tracks the expected preamble
//   sequence (W after B/M, B/M after W). Each complete subframe yields one
//   vout strobe with the sample, channel/block flags, C bit, parity result
//   and the frame index within the 192-frame block.
//
//   Ports:
//     clk   system clock, one cell sampled per rising edge
//     rst   synchronous active-high reset
//     bus   subframe_decoder_if.master (din in, decoded sample out)
//
//   FSM states:
//     state    | meaning
//     ---------+------------------------------------------------------
//     HUNT     | unlocked, scanning every cell for any preamble pattern
//     RECEIVE  | locked, decoding cells 8..63 of the current subframe
//     PREAMBLE | locked, collecting cells 0..7 of the next preamble
// ---------------------------------------------------------------------------
module subframe_decoder (
  input  logic               clk,
  input  logic               rst,
  subframe_decoder_if.master bus
);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    RECEIVE  = 2'd1,
    PREAMBLE = 2'd2
  } state_t;

  localparam logic [1:0] PT_B       = 2'd0;
  localparam logic [1:0] PT_M       = 2'd1;
  localparam logic [1:0] PT_W       = 2'd2;
  localparam logic [7:0] FRAME_LAST = 8'd191;
  localparam logic [5:0] CELL_PRE_END  = 6'd7;
  localparam logic [5:0] CELL_BODY     = 6'd8;
  localparam logic [5:0] CELL_DATA_LO  = 6'd17;
  localparam logic [5:0] CELL_DATA_HI  = 6'd55;
  localparam logic [5:0] CELL_C        = 6'd61;
  localparam logic [5:0] CELL_LAST     = 6'd63;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [7:0]  shreg;
  logic [7:0]  sh_next;
  logic [19:0] data_sr;
  logic        par;
  logic        c_lat;
  logic [1:0]  ptype;
  logic [7:0]  fcnt;

  logic        cell_xor;
  logic        first_cell;
  logic        data_cell;
  logic        pre_valid;
  logic [1:0]  pre_type;
  logic        pre_allowed;
  logic        accept;
  logic        violation;
  logic        deliver;

  // The cell sampled on this edge is already part of the compared window.
  assign sh_next = {shreg[6:0], bus.din};

  // On a first cell this must be 1 (mandatory transition); on a second
  // cell it is the decoded bit value.
  assign cell_xor   = shreg[0] ^ bus.din;
  assign first_cell = ~cnt[0];
  assign data_cell  = cnt[0] && (cnt >= CELL_DATA_LO) && (cnt <= CELL_DATA_HI);

  // Preamble classifier, both polarities of each type.
  always_comb begin
    pre_valid = 1'b0;
    pre_type  = PT_B;
    case (sh_next)
      8'b11101000, 8'b00010111: begin pre_valid = 1'b1; pre_type = PT_B; end
      8'b11100010, 8'b00011101: begin pre_valid = 1'b1; pre_type = PT_M; end
      8'b11100100, 8'b00011011: begin pre_valid = 1'b1; pre_type = PT_W; end
      default: begin pre_valid = 1'b0; pre_type = PT_B; end
    endcase
  end

  // Left and right subframes must alternate once locked.
  assign pre_allowed = (ptype == PT_W) ? (pre_type != PT_W) : (pre_type == PT_W);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      HUNT: begin
        if (pre_valid) state_nx = RECEIVE;
      end
      RECEIVE: begin
        if (first_cell && !cell_xor) state_nx = HUNT;
        else if (cnt == CELL_LAST)   state_nx = PREAMBLE;
      end
      PREAMBLE: begin
        if (cnt == CELL_PRE_END) begin
          state_nx = (pre_valid && pre_allowed) ? RECEIVE : HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / event decode
  // -------------------------------------------------------------------------
  always_comb begin
    accept    = 1'b0;
    violation = 1'b0;
    deliver   = 1'b0;
    case (state)
      HUNT: begin
        accept = pre_valid;
      end
      RECEIVE: begin
        if (first_cell && !cell_xor) violation = 1'b1;
        else if (cnt == CELL_LAST)   deliver   = 1'b1;
      end
      PREAMBLE: begin
        if (cnt == CELL_PRE_END) begin
          if (pre_valid && pre_allowed) accept    = 1'b1;
          else                          violation = 1'b1;
        end
      end
      default: begin
        accept    = 1'b0;
        violation = 1'b0;
        deliver   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      shreg           <= '0;
      data_sr         <= '0;
      par             <= 1'b0;
      c_lat           <= 1'b0;
      ptype           <= PT_B;
      fcnt            <= '0;
      bus.dout        <= '0;
      bus.vout        <= 1'b0;
      bus.channel_b   <= 1'b0;
      bus.block_start <= 1'b0;
      bus.cbit        <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.frame_idx   <= '0;
      bus.locked      <= 1'b0;
      bus.sync_err    <= 1'b0;
    end else begin
      shreg        <= sh_next;
      bus.vout     <= deliver;
      bus.sync_err <= violation;

      if (accept)                     cnt <= CELL_BODY;
      else if (deliver || violation)  cnt <= '0;
      else if (state == HUNT)         cnt <= '0;
      else                            cnt <= cnt + 6'd1;

      if (accept)         bus.locked <= 1'b1;
      else if (violation) bus.locked <= 1'b0;

      if (accept) begin
        ptype <= pre_type;
        if (pre_type == PT_B) begin
          fcnt <= '0;
        end else if (pre_type == PT_M) begin
          fcnt <= (fcnt == FRAME_LAST) ? 8'd0 : fcnt + 8'd1;
        end
      end

      if ((state == RECEIVE) && cnt[0]) begin
        par <= par ^ cell_xor;
        if (data_cell)        data_sr <= {data_sr[18:0], cell_xor};
        if (cnt == CELL_C)    c_lat   <= cell_xor;
      end

      // The P bit is decoded on this same edge, so fold it in directly.
      if (deliver) begin
        bus.dout        <= data_sr;
        bus.channel_b   <= (ptype == PT_W);
        bus.block_start <= (ptype == PT_B);
        bus.cbit        <= c_lat;
        bus.parity_err  <= par ^ cell_xor;
        bus.frame_idx   <= fcnt;
        par             <= 1'b0;
      end

      if (violation) begin
        par     <= 1'b0;
        data_sr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_subframe_decoder.sv
// ---------------------------------------------------------------------------
// tb_subframe_decoder
//   Drives biphase-mark subframes into subframe_decoder. Expected samples
//   are queued when a subframe's last cell is driven and compared when vout
//   appears. A table covers the basic subframe cases; hand-written
//   sequences cover the full block, the W-W error and mid-subframe reset.
// ---------------------------------------------------------------------------
module tb_subframe_decoder;

  localparam logic [1:0] PT_B = 2'd0;
  localparam logic [1:0] PT_M = 2'd1;
  localparam logic [1:0] PT_W = 2'd2;

  typedef struct {
    logic [1:0]  pt;
    logic [19:0] data;
    logic [3:0]  aux;
    logic        c;
    bit          bad_par;
    bit          brk;
    bit          exp_v;
    logic [7:0]  exp_fidx;
    bit          exp_lk8;
    bit          exp_lk_end;
    bit          exp_sync;
  } sf_t;

  typedef struct {
    logic [19:0] dout;
    logic        chb;
    logic        blk;
    logic        c;
    logic        perr;
    logic [7:0]  fidx;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  subframe_decoder_if bus();

  subframe_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   sync_cnt = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic lvl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every vout must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.sync_err === 1'b1) sync_cnt++;
    if (bus.vout === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vout: got vout=1 expected none (cycle %0d)", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("dout",        int'(bus.dout),        int'(e_mon.dout));
        chk("channel_b",   int'(bus.channel_b),   int'(e_mon.chb));
        chk("block_start", int'(bus.block_start), int'(e_mon.blk));
        chk("cbit",        int'(bus.cbit),        int'(e_mon.c));
        chk("parity_err",  int'(bus.parity_err),  int'(e_mon.perr));
        chk("frame_idx",   int'(bus.frame_idx),   int'(e_mon.fidx));
        chk("vout_cycle",  cyc,                   e_mon.cyc);
        chk("locked_at_vout", int'(bus.locked),   1);
      end
    end
  end

  // Biphase-mark encode one subframe; preamble polarity follows the line level.
  task automatic build(input sf_t s, input logic lv_in, output logic [0:63] cells);
    logic [7:0]  pat;
    logic [27:0] bits;
    logic        lv;
    logic        f;
    logic        p;
    case (s.pt)
      PT_B:    pat = 8'b11101000;
      PT_M:    pat = 8'b11100010;
      default: pat = 8'b11100100;
    endcase
    if (lv_in) pat = ~pat;
    for (int k = 0; k < 8; k++) cells[k] = pat[7-k];
    bits    = {s.aux, s.data, 1'b0, 1'b1, s.c, 1'b0};
    p       = ^bits[27:1];
    bits[0] = s.bad_par ? ~p : p;
    lv      = cells[7];
    for (int j = 0; j < 28; j++) begin
      f              = ~lv;
      cells[8+2*j]   = f;
      cells[9+2*j]   = bits[27-j] ? ~f : f;
      lv             = cells[9+2*j];
    end
    if (s.brk) cells[17] = cells[18];
  endtask

  task automatic send(input sf_t s, input int rst_cell);
    logic [0:63] cells;
    logic        lk8;
    logic        lk_end;
    int          s0;
    int          sync_d;
    exp_t        e;
    build(s, lvl, cells);
    lvl    = cells[63];
    s0     = sync_cnt;
    lk8    = 1'b0;
    lk_end = 1'b0;
    sync_d = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 8) lk8 = bus.locked;
      if (rst_cell >= 0 && k == rst_cell + 1) begin
        rst = 1'b0;
        chk("rst_dout",        int'(bus.dout),        0);
        chk("rst_vout",        int'(bus.vout),        0);
        chk("rst_channel_b",   int'(bus.channel_b),   0);
        chk("rst_block_start", int'(bus.block_start), 0);
        chk("rst_cbit",        int'(bus.cbit),        0);
        chk("rst_parity_err",  int'(bus.parity_err),  0);
        chk("rst_frame_idx",   int'(bus.frame_idx),   0);
        chk("rst_locked",      int'(bus.locked),      0);
        chk("rst_sync_err",    int'(bus.sync_err),    0);
      end
      if (k == 63) begin
        lk_end = bus.locked;
        sync_d = sync_cnt - s0;
      end
      bus.din = cells[k];
      if (k == rst_cell) rst = 1'b1;
      if (k == 63 && s.exp_v) begin
        e.dout = s.data;
        e.chb  = (s.pt == PT_W);
        e.blk  = (s.pt == PT_B);
        e.c    = s.c;
        e.perr = s.bad_par;
        e.fidx = s.exp_fidx;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
    end
    chk("locked_after_preamble", int'(lk8),    int'(s.exp_lk8));
    chk("locked_end",            int'(lk_end), int'(s.exp_lk_end));
    chk("sync_err_pulses",       sync_d,       int'(s.exp_sync));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sf_t tbl[8];
    sf_t s;

    //        pt    data       aux    c     badp brk  v  fidx  lk8 lkend sync
    tbl[0] = '{PT_B, 20'hABCDE, 4'h0, 1'b1, 0,   0,   1, 8'd0, 1,  1,    0};
    tbl[1] = '{PT_W, 20'h12345, 4'h3, 1'b0, 0,   0,   1, 8'd0, 1,  1,    0};
    tbl[2] = '{PT_M, 20'h0F0F0, 4'h5, 1'b0, 1,   0,   1, 8'd1, 1,  1,    0};
    tbl[3] = '{PT_W, 20'h55555, 4'h9, 1'b1, 0,   1,   0, 8'd0, 1,  0,    1};
    tbl[4] = '{PT_M, 20'h9A5C3, 4'hA, 1'b1, 0,   0,   1, 8'd2, 1,  1,    0};
    tbl[5] = '{PT_W, 20'hFFFFF, 4'hF, 1'b0, 0,   0,   1, 8'd2, 1,  1,    0};
    tbl[6] = '{PT_B, 20'h00000, 4'h6, 1'b1, 0,   0,   1, 8'd0, 1,  1,    0};
    tbl[7] = '{PT_W, 20'h80001, 4'hC, 1'b1, 0,   0,   1, 8'd0, 1,  1,    0};

    rst     = 1'b1;
    bus.din = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout",        int'(bus.dout),        0);
    chk("reset_vout",        int'(bus.vout),        0);
    chk("reset_channel_b",   int'(bus.channel_b),   0);
    chk("reset_block_start", int'(bus.block_start), 0);
    chk("reset_cbit",        int'(bus.cbit),        0);
    chk("reset_parity_err",  int'(bus.parity_err),  0);
    chk("reset_frame_idx",   int'(bus.frame_idx),   0);
    chk("reset_locked",      int'(bus.locked),      0);
    chk("reset_sync_err",    int'(bus.sync_err),    0);
    rst = 1'b0;

    repeat (40) @(negedge clk);
    chk("idle_locked",   int'(bus.locked), 0);
    chk("idle_sync_err", sync_cnt,         0);

    // After a long run of zeros a 1-first preamble would briefly look like
    // an M pattern to the hunter, so start with the 0-first polarity.
    lvl = 1'b1;
    for (int i = 0; i < 8; i++) send(tbl[i], -1);

    // Full 192-frame block: B, W, M, W, ... frame_idx 0..191.
    for (int i = 0; i < 384; i++) begin
      s.pt         = (i % 2 == 1) ? PT_W : ((i == 0) ? PT_B : PT_M);
      s.data       = 20'($urandom);
      s.aux        = 4'($urandom);
      s.c          = 1'($urandom);
      s.bad_par    = 1'b0;
      s.brk        = 1'b0;
      s.exp_v      = 1'b1;
      s.exp_fidx   = 8'(i / 2);
      s.exp_lk8    = 1'b1;
      s.exp_lk_end = 1'b1;
      s.exp_sync   = 1'b0;
      send(s, -1);
    end

    // Block wrap, then W followed by W loses lock at the preamble.
    send('{PT_B, 20'h13579, 4'h1, 1'b1, 0, 0, 1, 8'd0, 1, 1, 0}, -1);
    send('{PT_W, 20'h2468A, 4'h2, 1'b0, 0, 0, 1, 8'd0, 1, 1, 0}, -1);
    send('{PT_W, 20'h77777, 4'h4, 1'b1, 0, 0, 0, 8'd0, 0, 0, 1}, -1);

    // Relock, then reset in the middle of a B subframe.
    send('{PT_M, 20'hC0FFE, 4'h8, 1'b0, 0, 0, 1, 8'd1, 1, 1, 0}, -1);
    send('{PT_W, 20'hBEEF1, 4'h7, 1'b1, 0, 0, 1, 8'd1, 1, 1, 0}, -1);
    send('{PT_B, 20'h5A5A5, 4'hE, 1'b1, 0, 0, 0, 8'd0, 1, 0, 0}, 30);
    send('{PT_W, 20'h3C3C3, 4'hB, 1'b1, 0, 0, 1, 8'd0, 1, 1, 0}, -1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subframe_decoder.md
SUBFRAME_DECODER -- requirements
Module: subframe_decoder

Interface
REQ-001 clk  input  1  6.144 MHz system clock; one biphase half-bit cell per cycle.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 din  input  1  serial biphase-mark subframe stream, one cell sampled per rising edge of clk.
REQ-004 dout  output  20  decoded audio sample, MSB first on the wire.
REQ-005 vout  output  1  one-cycle pulse; dout and all per-sample flags valid.
REQ-006 channel_b  output  1  1 = W (right) preamble subframe; 0 = B or M (left) preamble subframe.
REQ-007 block_start  output  1  1 = sample came from a B preamble subframe.
REQ-008 cbit  output  1  decoded channel-status bit of the sample.
REQ-009 parity_err  output  1  even-parity failure on the sample.
REQ-010 frame_idx  output  8  frame number within the 192-frame block.
REQ-011 locked  output  1  decoder is synchronised to the subframe stream.
REQ-012 sync_err  output  1  one-cycle pulse on loss of lock.

Function
REQ-013 Subframe format: 64 cells.
- cells 0-7: preamble.
- cells 8-63: 28 bits, two cells each, in this order: 4 aux, 20 data (bit 19 first), V, U, C, P.
REQ-014 Preamble patterns, first cell leftmost, two variants each:
- B: 11101000 or 00010111.
- M: 11100010 or 00011101.
- W: 11100100 or 00011011.
REQ-015 An 8-bit shift register shall hold the most recent 8 cells; the newest cell enters the LSB.
REQ-016 The FSM shall have three states: HUNT, RECEIVE, PREAMBLE.
REQ-017 HUNT: when the shift register (including the cell sampled this edge) equals any of the 6 patterns:
- go to RECEIVE with cell counter = 8;
- set locked = 1;
- latch the preamble type.
REQ-018 RECEIVE, even cell index (first cell of a bit): the cell shall differ from the previous cell; otherwise biphase violation.
REQ-019 RECEIVE, odd cell index: decoded bit = first cell XOR second cell.
- data bits shall shift into a 20-bit register;
- the C bit shall be latched;
- every decoded bit (aux through P) shall be XOR-accumulated into a parity register.
REQ-020 On the edge that samples cell 63 the block shall:
- register dout, channel_b, block_start, cbit and frame_idx;
- assert vout for one cycle;
- set parity_err = 1 iff the XOR of the 28 bits is 1;
- clear the parity register;
- go to PREAMBLE with cell counter = 0.
REQ-021 PREAMBLE: collect 8 cells. On cell 7 the register shall match an allowed type:
- after W: B or M is allowed;
- after B or M: W is allowed.
On a match, latch the type and go to RECEIVE at cell 8.
REQ-022 Biphase violation, or preamble mismatch/disallowed type, shall cause:
- go to HUNT;
- locked = 0;
- sync_err pulse for one cycle;
- no vout for the affected subframe;
- parity and data registers cleared.
REQ-023 frame_idx shall be updated at acceptance of each left preamble:
- B sets it to 0;
- M increments it, wrapping 191 to 0;
- W leaves it unchanged.
REQ-024 A sample delivered with parity_err = 1 shall still be output with vout; lock shall be kept.
REQ-025 No backpressure: vout pulses at most once per 64 cycles and the consumer shall accept every pulse.
REQ-026 All outputs except vout and sync_err shall hold their values between pulses.

Reset
REQ-027 On rst:
- state = HUNT, cell counter = 0;
- shift, data and parity registers = 0;
- dout = 0, vout = 0, channel_b = 0, block_start = 0, cbit = 0, parity_err = 0, frame_idx = 0, locked = 0, sync_err = 0.
REQ-028 rst asserted mid-subframe shall abort that subframe with no vout and no sync_err; decoding shall resume only via a HUNT match.

Verification
REQ-029 Reset, then an idle 0 stream, then a B subframe carrying 20'hABCDE, C=1 -> one vout on the cell-63 edge with:
- dout = 20'hABCDE, block_start = 1, channel_b = 0, cbit = 1, frame_idx = 0, parity_err = 0;
- locked = 1 from the preamble match onward.
REQ-030 The next W subframe carrying 20'h12345 -> vout exactly 64 cycles later with dout = 20'h12345, channel_b = 1, block_start = 0.
REQ-031 Subframe with the P bit cells inverted (biphase still valid) -> vout with parity_err = 1, correct dout, locked stays 1.
REQ-032 Second cell of data bit 19 copied from the first cell of the next bit, breaking the even-cell transition -> sync_err pulse, locked = 0, no vout; relock and a correct sample on the next valid preamble.
REQ-033 Full block of 384 subframes (first left B, then M) -> frame_idx runs 0..191; the next B gives frame_idx = 0; W then W -> sync_err.
REQ-034 rst pulsed at cell 30 of a subframe -> all outputs 0 the next cycle, no vout for that subframe, relock on the following preamble.
